// File: rtl/dtls_rx_pkg.sv
// Shared types for the DTLS receive arbiter: header field widths, record header payload, FSM encoding.
package dtls_rx_pkg;

  localparam logic [7:0]  DTLS_TYPE_APP_DATA = 8'd23;

  localparam int unsigned TYPE_W  = 8;
  localparam int unsigned EPOCH_W = 16;
  localparam int unsigned SEQ_W   = 48;
  localparam int unsigned LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [TYPE_W-1:0]  rec_type;
    logic [EPOCH_W-1:0] epoch;
    logic [SEQ_W-1:0]   seqnum;
    logic [LEN_W-1:0]   length;
  } dtls_hdr_t;

endpackage

// File: rtl/dtls_rx_arb_64_rr_grant_sel.sv
// Combinational rotating-priority select: first requester after last_grant, wrapping modulo PORTS.
module rr_grant_sel #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    last_grant,
  output logic [PW-1:0]    grant,
  output logic             grant_valid
);

  int unsigned idx;
  logic [PW-1:0] idx_w;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      // last_grant is always below PORTS, so a single subtraction wraps correctly
      idx = 32'(last_grant) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      idx_w = PW'(idx);
      if (!grant_valid && req[idx_w]) begin
        grant       = idx_w;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtls_rx_arb_64.sv
// Record-granular round-robin merge of PORTS DTLS rx header+payload streams onto one output.
// Optional feature: DTLS_RX_ARB_TYPE_FILTER_EN drops non-application_data records upstream.
module dtls_rx_arb_64
  import dtls_rx_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int unsigned PW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [PORTS-1:0]              s_dtls_hdr_valid,
  output logic [PORTS-1:0]              s_dtls_hdr_ready,
  input  logic [PORTS*TYPE_W-1:0]       s_dtls_type,
  input  logic [PORTS*EPOCH_W-1:0]      s_dtls_epoch,
  input  logic [PORTS*SEQ_W-1:0]        s_dtls_seqnum,
  input  logic [PORTS*LEN_W-1:0]        s_dtls_length,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_dtls_payload_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_dtls_payload_axis_tkeep,
  input  logic [PORTS-1:0]              s_dtls_payload_axis_tvalid,
  output logic [PORTS-1:0]              s_dtls_payload_axis_tready,
  input  logic [PORTS-1:0]              s_dtls_payload_axis_tlast,
  input  logic [PORTS-1:0]              s_dtls_payload_axis_tuser,

  output logic                          m_dtls_hdr_valid,
  input  logic                          m_dtls_hdr_ready,
  output logic [TYPE_W-1:0]             m_dtls_type,
  output logic [EPOCH_W-1:0]            m_dtls_epoch,
  output logic [SEQ_W-1:0]              m_dtls_seqnum,
  output logic [LEN_W-1:0]              m_dtls_length,
  output logic [PW-1:0]                 m_dtls_port,
  output logic [DATA_WIDTH-1:0]         m_dtls_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_dtls_payload_axis_tkeep,
  output logic                          m_dtls_payload_axis_tvalid,
  input  logic                          m_dtls_payload_axis_tready,
  output logic                          m_dtls_payload_axis_tlast,
  output logic                          m_dtls_payload_axis_tuser,

  output logic                          busy
);

  arb_state_t state, state_n;
  dtls_hdr_t  hdr_q;
  logic [PW-1:0] cur_port, last_grant, gnt_idx;
  logic gnt_valid, hdr_load, rec_done;

  dtls_hdr_t             hdr_a  [PORTS];
  logic [DATA_WIDTH-1:0] data_a [PORTS];
  logic [KEEP_WIDTH-1:0] keep_a [PORTS];

  // Unpack the flat per-port buses into indexable arrays
  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign hdr_a[i].rec_type = s_dtls_type[i*TYPE_W +: TYPE_W];
    assign hdr_a[i].epoch    = s_dtls_epoch[i*EPOCH_W +: EPOCH_W];
    assign hdr_a[i].seqnum   = s_dtls_seqnum[i*SEQ_W +: SEQ_W];
    assign hdr_a[i].length   = s_dtls_length[i*LEN_W +: LEN_W];
    assign data_a[i]         = s_dtls_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign keep_a[i]         = s_dtls_payload_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
  end

  rr_grant_sel #(.PORTS(PORTS), .PW(PW)) u_sel (
    .req         (s_dtls_hdr_valid),
    .last_grant  (last_grant),
    .grant       (gnt_idx),
    .grant_valid (gnt_valid)
  );

  assign m_dtls_type   = hdr_q.rec_type;
  assign m_dtls_epoch  = hdr_q.epoch;
  assign m_dtls_seqnum = hdr_q.seqnum;
  assign m_dtls_length = hdr_q.length;
  assign m_dtls_port   = cur_port;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state plus the zero-latency handshake/payload mux; held quiet during reset
  always_comb begin
    state_n                    = state;
    hdr_load                   = 1'b0;
    rec_done                   = 1'b0;
    s_dtls_hdr_ready           = '0;
    s_dtls_payload_axis_tready = '0;
    m_dtls_payload_axis_tdata  = '0;
    m_dtls_payload_axis_tkeep  = '0;
    m_dtls_payload_axis_tvalid = 1'b0;
    m_dtls_payload_axis_tlast  = 1'b0;
    m_dtls_payload_axis_tuser  = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            s_dtls_hdr_ready[gnt_idx] = 1'b1;
            hdr_load                  = 1'b1;
`ifdef DTLS_RX_ARB_TYPE_FILTER_EN
            state_n = (hdr_a[gnt_idx].rec_type == DTLS_TYPE_APP_DATA) ? ST_HDR : ST_DROP;
`else
            state_n = ST_HDR;
`endif
          end
        end
        ST_HDR: begin
          if (m_dtls_hdr_ready) state_n = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          s_dtls_payload_axis_tready[cur_port] = m_dtls_payload_axis_tready;
          m_dtls_payload_axis_tvalid = s_dtls_payload_axis_tvalid[cur_port];
          m_dtls_payload_axis_tdata  = data_a[cur_port];
          m_dtls_payload_axis_tkeep  = keep_a[cur_port];
          m_dtls_payload_axis_tlast  = s_dtls_payload_axis_tlast[cur_port];
          m_dtls_payload_axis_tuser  = s_dtls_payload_axis_tuser[cur_port];
          if (s_dtls_payload_axis_tvalid[cur_port] && m_dtls_payload_axis_tready &&
              s_dtls_payload_axis_tlast[cur_port]) begin
            rec_done = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        ST_DROP: begin
`ifdef DTLS_RX_ARB_TYPE_FILTER_EN
          s_dtls_payload_axis_tready[cur_port] = 1'b1;
          if (s_dtls_payload_axis_tvalid[cur_port] && s_dtls_payload_axis_tlast[cur_port]) begin
            rec_done = 1'b1;
            state_n  = ST_IDLE;
          end
`else
          state_n = ST_IDLE;
`endif
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Header capture, grant bookkeeping and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= 1'b0;
      cur_port         <= '0;
      last_grant       <= PW'(PORTS - 1);
      hdr_q            <= '0;
      m_dtls_hdr_valid <= 1'b0;
    end else begin
      busy <= (state_n != ST_IDLE);
      if (hdr_load) begin
        cur_port         <= gnt_idx;
        hdr_q            <= hdr_a[gnt_idx];
        m_dtls_hdr_valid <= (state_n == ST_HDR);
      end else if (state == ST_HDR && m_dtls_hdr_ready) begin
        m_dtls_hdr_valid <= 1'b0;
      end
      if (rec_done) last_grant <= cur_port;
    end
  end

endmodule

// File: tb/tb_dtls_rx_arb_64.sv
// Self-checking bench for dtls_rx_arb_64: directed scenarios plus randomized traffic against a record-level model.
module tb_dtls_rx_arb_64;

  localparam int P  = 3;
  localparam int PW = 2;

  typedef struct packed {
    logic [7:0]  t;
    logic [15:0] e;
    logic [47:0] s;
    logic [15:0] l;
  } hdr_t;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        la;
    logic        u;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [P-1:0]    s_dtls_hdr_valid, s_dtls_hdr_ready;
  logic [P*8-1:0]  s_dtls_type;
  logic [P*16-1:0] s_dtls_epoch, s_dtls_length;
  logic [P*48-1:0] s_dtls_seqnum;
  logic [P*64-1:0] s_tdata;
  logic [P*8-1:0]  s_tkeep;
  logic [P-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic            m_dtls_hdr_valid, m_dtls_hdr_ready;
  logic [7:0]      m_dtls_type;
  logic [15:0]     m_dtls_epoch, m_dtls_length;
  logic [47:0]     m_dtls_seqnum;
  logic [PW-1:0]   m_dtls_port;
  logic [63:0]     m_tdata;
  logic [7:0]      m_tkeep;
  logic            m_tvalid, m_tready, m_tlast, m_tuser, busy;

  dtls_rx_arb_64 #(.PORTS(P)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_dtls_hdr_valid           (s_dtls_hdr_valid),
    .s_dtls_hdr_ready           (s_dtls_hdr_ready),
    .s_dtls_type                (s_dtls_type),
    .s_dtls_epoch               (s_dtls_epoch),
    .s_dtls_seqnum              (s_dtls_seqnum),
    .s_dtls_length              (s_dtls_length),
    .s_dtls_payload_axis_tdata  (s_tdata),
    .s_dtls_payload_axis_tkeep  (s_tkeep),
    .s_dtls_payload_axis_tvalid (s_tvalid),
    .s_dtls_payload_axis_tready (s_tready),
    .s_dtls_payload_axis_tlast  (s_tlast),
    .s_dtls_payload_axis_tuser  (s_tuser),
    .m_dtls_hdr_valid           (m_dtls_hdr_valid),
    .m_dtls_hdr_ready           (m_dtls_hdr_ready),
    .m_dtls_type                (m_dtls_type),
    .m_dtls_epoch               (m_dtls_epoch),
    .m_dtls_seqnum              (m_dtls_seqnum),
    .m_dtls_length              (m_dtls_length),
    .m_dtls_port                (m_dtls_port),
    .m_dtls_payload_axis_tdata  (m_tdata),
    .m_dtls_payload_axis_tkeep  (m_tkeep),
    .m_dtls_payload_axis_tvalid (m_tvalid),
    .m_dtls_payload_axis_tready (m_tready),
    .m_dtls_payload_axis_tlast  (m_tlast),
    .m_dtls_payload_axis_tuser  (m_tuser),
    .busy                       (busy)
  );

  always #5 clk = ~clk;

  // Upstream sources: per-port pending headers and payload beats
  hdr_t  hq [P][$];
  beat_t bq [P][$];
  logic [P-1:0] tvh;

  // Record-level model: 0 waiting for grant, 1 header offered, 2 payload, 3 discarding
  int   ph, g, last_g;
  hdr_t cur;
  int   grant_log[$], port_log[$];
  int   beats_out, beats_dropped;
  int   tv_pct, hr_pct, tr_pct;
  bit   tr_toggle, tgl;
  int   checks, failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [P-1:0] req, input int lst);
    for (int i = 1; i <= P; i++) begin
      if (req[(lst + i) % P]) return (lst + i) % P;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int p = 0; p < P; p++) if (hq[p].size() > 0 || bq[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic zero_inputs();
    s_dtls_hdr_valid = '0; s_dtls_type = '0; s_dtls_epoch = '0;
    s_dtls_seqnum = '0; s_dtls_length = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    m_dtls_hdr_ready = 1'b0; m_tready = 1'b0;
  endtask

  task automatic add_rec(input int p, input logic [7:0] t, input logic [15:0] len, input int nb);
    hdr_t h;
    beat_t b;
    h.t = t; h.e = 16'($urandom); h.s = 48'({$urandom, $urandom}); h.l = len;
    hq[p].push_back(h);
    for (int i = 0; i < nb; i++) begin
      b.d  = {$urandom, $urandom};
      b.k  = (i == nb - 1) ? 8'($urandom_range(255, 1)) : 8'hFF;
      b.la = (i == nb - 1);
      b.u  = 1'($urandom_range(1));
      bq[p].push_back(b);
    end
  endtask

  // One clock: drive sources, check DUT against the model, then advance the model
  task automatic cycle();
    logic [P-1:0] exp_hr, exp_tr;
    int pk;
    beat_t b;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      hdr_t h;
      beat_t bb;
      h = '0; bb = '0;
      if (hq[p].size() > 0) h = hq[p][0];
      s_dtls_hdr_valid[p]      = (hq[p].size() > 0);
      s_dtls_type[p*8 +: 8]    = h.t;
      s_dtls_epoch[p*16 +: 16] = h.e;
      s_dtls_seqnum[p*48 +: 48] = h.s;
      s_dtls_length[p*16 +: 16] = h.l;
      tvh[p] = (bq[p].size() > 0) && (tvh[p] || (int'($urandom_range(99)) < tv_pct));
      if (bq[p].size() > 0) bb = bq[p][0];
      s_tvalid[p]          = tvh[p];
      s_tdata[p*64 +: 64]  = bb.d;
      s_tkeep[p*8 +: 8]    = bb.k;
      s_tlast[p]           = bb.la;
      s_tuser[p]           = bb.u;
    end
    m_dtls_hdr_ready = (int'($urandom_range(99)) < hr_pct);
    tgl = ~tgl;
    m_tready = tr_toggle ? tgl : (int'($urandom_range(99)) < tr_pct);
    #1;
    pk = rr_pick(s_dtls_hdr_valid, last_g);
    exp_hr = (ph == 0 && pk >= 0) ? (P'(1) << pk) : P'(0);
    exp_tr = (ph == 2 && m_tready) ? (P'(1) << g) : ((ph == 3) ? (P'(1) << g) : P'(0));
    chk("busy", 64'(busy), 64'(ph != 0));
    chk("s_hdr_ready", 64'(s_dtls_hdr_ready), 64'(exp_hr));
    chk("m_hdr_valid", 64'(m_dtls_hdr_valid), 64'(ph == 1));
    chk("s_tready", 64'(s_tready), 64'(exp_tr));
    chk("m_tvalid", 64'(m_tvalid), 64'((ph == 2) ? s_tvalid[g] : 1'b0));
    if (ph == 1) begin
      chk("m_port", 64'(m_dtls_port), 64'(g));
      chk("m_type", 64'(m_dtls_type), 64'(cur.t));
      chk("m_epoch", 64'(m_dtls_epoch), 64'(cur.e));
      chk("m_seqnum", 64'(m_dtls_seqnum), 64'(cur.s));
      chk("m_length", 64'(m_dtls_length), 64'(cur.l));
    end
    if (ph == 2 && s_tvalid[g] && m_tready) begin
      b = bq[g][0];
      chk("m_tdata", m_tdata, b.d);
      chk("m_tkeep", 64'(m_tkeep), 64'(b.k));
      chk("m_tlast", 64'(m_tlast), 64'(b.la));
      chk("m_tuser", 64'(m_tuser), 64'(b.u));
    end
    if (ph == 0 && pk >= 0) begin
      cur = hq[pk].pop_front();
      g = pk;
      grant_log.push_back(pk);
      ph = 1;
`ifdef DTLS_RX_ARB_TYPE_FILTER_EN
      if (cur.t != 8'd23) ph = 3;
`endif
    end else if (ph == 1 && m_dtls_hdr_ready) begin
      port_log.push_back(g);
      ph = 2;
    end else if ((ph == 2 && s_tvalid[g] && m_tready) || (ph == 3 && s_tvalid[g])) begin
      b = bq[g].pop_front();
      tvh[g] = 1'b0;
      if (ph == 2) beats_out++; else beats_dropped++;
      if (b.la) begin
        last_g = g;
        ph = 0;
      end
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n;
    n = 0;
    while ((pending() || ph != 0) && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < maxc) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d cycles expected=below %0d", tag, n, maxc);
    end
  endtask

  // Reset, then check every output at its reset value in the first cycle after release
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    zero_inputs();
    for (int p = 0; p < P; p++) begin
      hq[p].delete();
      bq[p].delete();
    end
    tvh = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_s_hdr_ready", 64'(s_dtls_hdr_ready), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_hdr_valid", 64'(m_dtls_hdr_valid), 64'd0);
    chk("rst_m_type", 64'(m_dtls_type), 64'd0);
    chk("rst_m_epoch", 64'(m_dtls_epoch), 64'd0);
    chk("rst_m_seqnum", 64'(m_dtls_seqnum), 64'd0);
    chk("rst_m_length", 64'(m_dtls_length), 64'd0);
    chk("rst_m_port", 64'(m_dtls_port), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    ph = 0; g = 0; last_g = P - 1;
    grant_log.delete();
    port_log.delete();
    beats_out = 0;
    beats_dropped = 0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; tgl = 1'b0; tr_toggle = 1'b0;
    tvh = '0;
    zero_inputs();
    repeat (2) @(posedge clk);
    do_reset();

    // Single port, two full-keep beats
    tv_pct = 100; hr_pct = 100; tr_pct = 100;
    add_rec(0, 8'd23, 16'h0010, 2);
    bq[0][1].k = 8'hFF;
    cycle();
    chk("t1_grant_now", 64'(grant_log.size()), 64'd1);
    drain("t1", 50);
    chk("t1_port", 64'(port_log.size() > 0 ? port_log[0] : 99), 64'd0);
    chk("t1_beats", 64'(beats_out), 64'd2);

    // Simultaneous requests on ports 0 and 1 alternate
    do_reset();
    for (int r = 0; r < 3; r++) begin
      add_rec(0, 8'd23, 16'(8 * (r + 1)), r + 1);
      add_rec(1, 8'd23, 16'(8 * (r + 2)), r + 2);
    end
    drain("t2", 200);
    chk("t2_count", 64'(port_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < port_log.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(port_log[i]), 64'(i % 2));

    // Toggling downstream ready on a 5-beat record from port 1
    do_reset();
    tr_toggle = 1'b1;
    add_rec(1, 8'd23, 16'd40, 5);
    drain("t3", 100);
    chk("t3_beats", 64'(beats_out), 64'd5);
    chk("t3_port", 64'(port_log.size() > 0 ? port_log[0] : 99), 64'd1);
    tr_toggle = 1'b0;

    // Reset in the middle of a 4-beat record on port 1
    do_reset();
    add_rec(1, 8'd23, 16'd32, 4);
    n = 0;
    while (beats_out < 1 && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_beat1_seen", 64'(beats_out), 64'd1);
    do_reset();
    add_rec(1, 8'd23, 16'd8, 1);
    add_rec(0, 8'd23, 16'd8, 1);
    cycle();
    chk("t4_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : 99), 64'd0);
    drain("t4", 50);

`ifdef DTLS_RX_ARB_TYPE_FILTER_EN
    // Non-application_data record is consumed without reaching the output
    do_reset();
    add_rec(0, 8'd22, 16'd24, 3);
    add_rec(0, 8'd23, 16'd8, 1);
    drain("t5", 50);
    chk("t5_hdrs_out", 64'(port_log.size()), 64'd1);
    chk("t5_beats_out", 64'(beats_out), 64'd1);
    chk("t5_beats_dropped", 64'(beats_dropped), 64'd3);
`endif

    // Randomized traffic across all ports with random backpressure
    do_reset();
    tv_pct = 60; hr_pct = 70; tr_pct = 70;
    for (int r = 0; r < 40; r++)
      add_rec(int'($urandom_range(P - 1)), ($urandom_range(3) == 0) ? 8'd22 : 8'd23,
              16'($urandom), int'($urandom_range(6, 1)));
    drain("rand", 5000);
    chk("rand_records", 64'(grant_log.size()), 64'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtls_rx_arb_64.md
# dtls_rx_arb_64

Packet-granular round-robin arbiter that merges the DTLS header and payload outputs of up to PORTS parallel DTLS receive pipelines onto one header-plus-64-bit-AXI-stream output. Each pipeline is an Ethernet→IP→UDP→DTLS receive chain. The block sits after the per-port DTLS receive modules and feeds the shared downstream payload consumer. It holds a grant for the whole record, from header acceptance to the payload beat carrying tlast. It tags each record with its source port.

## Interface
- PORTS, 2: number of DTLS receive pipelines. Legal range is 2–8.
- DATA_WIDTH, 64: payload width. Fixed at 64.
- KEEP_WIDTH, 8: DATA_WIDTH/8.
- clk  in  1  Single clock.
- rst  in  1  Reset. Synchronous, active-high.
- s_dtls_hdr_valid  in  PORTS  Per-port header valid.
- s_dtls_hdr_ready  out  PORTS  Per-port header accept. Reset value 0.
- s_dtls_type  in  PORTS*8  Packed per-port DTLS content type.
- s_dtls_epoch  in  PORTS*16  Packed epoch.
- s_dtls_seqnum  in  PORTS*48  Packed sequence number.
- s_dtls_length  in  PORTS*16  Packed record length.
- s_dtls_payload_axis_tdata  in  PORTS*64  Packed payload data.
- s_dtls_payload_axis_tkeep  in  PORTS*8  Packed payload keep.
- s_dtls_payload_axis_tvalid  in  PORTS  Payload valid.
- s_dtls_payload_axis_tready  out  PORTS  Payload ready. Reset value 0.
- s_dtls_payload_axis_tlast  in  PORTS  Payload last.
- s_dtls_payload_axis_tuser  in  PORTS  Payload error flag.
- m_dtls_hdr_valid  out  1  Merged header valid. Reset value 0.
- m_dtls_hdr_ready  in  1  Merged header accept.
- m_dtls_type, m_dtls_epoch, m_dtls_seqnum, m_dtls_length  out  8/16/48/16  Registered header fields. Reset value 0.
- m_dtls_port  out  clog2(PORTS)  Source port of the current record. Reset value 0.
- m_dtls_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out  64/8/1/1/1  Merged payload. Reset value 0.
- m_dtls_payload_axis_tready  in  1  Merged payload ready.
- busy  out  1  High in any state other than IDLE. Reset value 0.

## Operation
- The FSM has three states:
  - IDLE: if any s_dtls_hdr_valid is high, select the port by rotating priority starting at last_grant+1 modulo PORTS. Pulse s_dtls_hdr_ready[g] for one cycle, register the header fields and g, then go to HDR.
  - HDR: hold m_dtls_hdr_valid=1 until m_dtls_hdr_ready=1, then go to PAYLOAD.
  - PAYLOAD: combinationally route port g's payload to the output. s_tready[g] = m_tready; all other ports have s_tready=0. On a handshake with tlast=1, set last_grant := g and go to IDLE.
- Ports that are not granted see hdr_ready=0 and tready=0 at all times. Their data is held upstream; nothing is dropped.
- Payload that arrives before its header is accepted downstream stays stalled. Payload flows only in PAYLOAD.
- tuser passes through unmodified. The arbiter does not check s_dtls_length against the beat count.
- Round-robin fairness: a port that is continuously requesting waits at most PORTS-1 records.
- Reset takes effect in any state, including mid-payload:
  - The FSM returns to IDLE and all outputs return to their reset values.
  - last_grant := PORTS-1, so port 0 wins first after reset.
  - The partial record upstream is not flushed; flushing it is upstream's responsibility.

## Timing
- Latency from header to output: with s_dtls_hdr_valid high at cycle N in IDLE, s_dtls_hdr_ready pulses at N and m_dtls_hdr_valid rises at N+1.
- The first payload beat can transfer in the cycle after the m header handshake.
- The payload path has zero added latency. tvalid, tready, tdata and tlast are combinational through the mux while in PAYLOAD.
- Back-to-back record gap: the tlast handshake at cycle M is followed by IDLE at M+1, with a new header grant in that same cycle. There is a minimum of 2 idle cycles on the payload output between records.
- m_dtls_hdr_valid is never asserted while the FSM is in PAYLOAD.

## Configuration
- DTLS_RX_ARB_TYPE_FILTER_EN, when defined:
  - A granted header whose type is not 23 (application_data) skips HDR.
  - The FSM enters DROP state. In DROP, s_tready[g]=1, m_tvalid=0, and no m header is issued. On the tlast beat, last_grant := g and the FSM returns to IDLE.
- When not defined: the DROP state does not exist and every record is forwarded regardless of type.

## Structure
- Package dtls_rx_pkg holds:
  - DTLS_TYPE_APP_DATA = 8'd23.
  - The header field widths: 8/16/48/16.
  - The FSM state encoding: IDLE, HDR, PAYLOAD, DROP.
- One sub-module, rr_grant_sel: combinational rotating-priority select. Inputs are req[PORTS] and last_grant. Outputs are grant index and grant_valid.

## Test plan
- Single port: port 0 sends a header with length 0x0010 and 2 beats, tkeep 0xFF then 0xFF, tlast on beat 2. Required: m_dtls_hdr_valid rises 1 cycle after the request, m_dtls_port=0, and both beats arrive intact.
- Simultaneous requests on ports 0 and 1 right after reset, with 3 records each. Required output order of m_dtls_port: 0,1,0,1,0,1.
- Downstream backpressure: m_tready toggles every cycle during a 5-beat record on port 1. Required: no beat lost or duplicated, and port 0 tready stays 0 throughout.
- Reset asserted on beat 2 of 4. Required: the next cycle has every output at 0 and busy=0, and the next grant goes to port 0.
- With DTLS_RX_ARB_TYPE_FILTER_EN defined: port 0 sends type 22 with 3 beats, then type 23 with 1 beat. Required: the first record is fully consumed with no m header and m_tvalid=0, and only the type 23 record appears at the output.
